// File: rtl/btn_debounce_if.sv
// Button conditioner bundle: raw pin toward the debouncer, clean level and events back.
// The bench or board wrapper holds the master side; btn_debounce holds the slave side.
interface btn_debounce_if;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;
    logic btn_long;
    logic btn_held;

    modport master (
        output btn_in,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long,
        input  btn_held
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long,
        output btn_held
    );
endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: synchroniser, run-length debounce FSM, and registered
// level/press/release/long-press outputs for the LED/PWM logic.
module btn_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int LONG_CYCLES     = 25000000,
    parameter int ACTIVE_LOW      = 0,
    parameter int CTR_WIDTH       = 25
) (
    input  logic           clk,
    input  logic           rst_n,
    btn_debounce_if.slave  bus
);

    localparam logic                 INACTIVE  = logic'(ACTIVE_LOW != 0);
    localparam logic [CTR_WIDTH-1:0] DB_LAST   = CTR_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] LONG_LAST = CTR_WIDTH'(LONG_CYCLES - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_ONE   = CTR_WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        LONG_HELD,
        RELEASE_WAIT
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;

    state_t                 state, state_next, prev_state;
    logic [CTR_WIDTH-1:0]   dbctr, dbctr_next;
    logic [CTR_WIDTH-1:0]   lctr, lctr_next;
    logic                   origin_long, origin_next;

    logic level_next, press_next, release_next, long_next, held_next;

    // Synchroniser stage: parks at the idle pin level during reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync <= {SYNC_STAGES{INACTIVE}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], bus.btn_in};
        end
    end

    assign s = sync[SYNC_STAGES-1] ^ INACTIVE;

    // FSM / counter stage
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            prev_state  <= IDLE;
            dbctr       <= '0;
            lctr        <= '0;
            origin_long <= 1'b0;
        end else begin
            state       <= state_next;
            prev_state  <= state;
            dbctr       <= dbctr_next;
            lctr        <= lctr_next;
            origin_long <= origin_next;
        end
    end

    always_comb begin
        state_next  = state;
        dbctr_next  = dbctr;
        lctr_next   = lctr;
        origin_next = origin_long;
        case (state)
            IDLE: begin
                if (s) begin
                    state_next = PRESS_WAIT;
                    dbctr_next = CTR_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_next = IDLE;
                end else if (dbctr == DB_LAST) begin
                    state_next = PRESSED;
                    lctr_next  = '0;
                end else begin
                    dbctr_next = dbctr + CTR_ONE;
                end
            end
            PRESSED: begin
                // A release sample wins over the long terminal count.
                if (!s) begin
                    state_next  = RELEASE_WAIT;
                    dbctr_next  = CTR_ONE;
                    origin_next = 1'b0;
                end else if (lctr == LONG_LAST) begin
                    state_next = LONG_HELD;
                end else begin
                    lctr_next = lctr + CTR_ONE;
                end
            end
            LONG_HELD: begin
                if (!s) begin
                    state_next  = RELEASE_WAIT;
                    dbctr_next  = CTR_ONE;
                    origin_next = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_next = origin_long ? LONG_HELD : PRESSED;
                end else if (dbctr == DB_LAST) begin
                    state_next = IDLE;
                end else begin
                    dbctr_next = dbctr + CTR_ONE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output stage: pulses fire on the first cycle of a state, keyed on the state it came from,
    // so bouncing back out of RELEASE_WAIT never re-emits press or long.
    always_comb begin
        level_next   = (state == PRESSED) || (state == LONG_HELD) || (state == RELEASE_WAIT);
        press_next   = (state == PRESSED)   && (prev_state == PRESS_WAIT);
        long_next    = (state == LONG_HELD) && (prev_state == PRESSED);
        release_next = (state == IDLE)      && (prev_state == RELEASE_WAIT);
        held_next    = (state == LONG_HELD) || ((state == RELEASE_WAIT) && origin_long);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.btn_level   <= 1'b0;
            bus.btn_press   <= 1'b0;
            bus.btn_release <= 1'b0;
            bus.btn_long    <= 1'b0;
            bus.btn_held    <= 1'b0;
        end else begin
            bus.btn_level   <= level_next;
            bus.btn_press   <= press_next;
            bus.btn_release <= release_next;
            bus.btn_long    <= long_next;
            bus.btn_held    <= held_next;
        end
    end

endmodule
